// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared mode encodings and direction constants for the LED sequencer
package led_seq_pkg;
    typedef enum logic [1:0] {
        MODE_HOLD     = 2'd0,
        MODE_STEP     = 2'd1,
        MODE_AUTO     = 2'd2,
        MODE_PINGPONG = 2'd3
    } mode_t;
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;
endpackage

// File: rtl/led_sequencer_btn.sv
// btn_conditioner: button synchroniser, optional debouncer (LED_SEQ_DEBOUNCE_EN) and press-edge detector
module btn_conditioner #(
    parameter int DB_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic botao,
    output logic pressed,
    output logic press_evt
);
    logic [1:0] sync;
    logic       filt;
    logic       filt_q;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) sync <= 2'b11;
        else sync <= {sync[0], botao};
    end
`ifdef LED_SEQ_DEBOUNCE_EN
    localparam int DB_W = $clog2(DB_CYCLES + 1);
    logic [DB_W-1:0] db_cnt;
    // any bounce back to the accepted level restarts the stability count
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            filt   <= 1'b1;
            db_cnt <= '0;
        end else if (sync[1] == filt) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_W'(DB_CYCLES - 1)) begin
            filt   <= sync[1];
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end
`else
    assign filt = sync[1];
`endif
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) filt_q <= 1'b1;
        else filt_q <= filt;
    end
    assign pressed   = ~filt;
    assign press_evt = filt_q & ~filt;
endmodule

// File: rtl/led_sequencer.sv
// led_sequencer: one-hot N-LED sequencer with hold/step/auto/ping-pong modes
// Debounced button path is built when LED_SEQ_DEBOUNCE_EN is defined.
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int NUM_LEDS  = 4,
    parameter int PERIOD    = 15000000,
    parameter int DB_CYCLES = 500000,
    localparam int IDX_W    = $clog2(NUM_LEDS),
    localparam int CNT_W    = $clog2(PERIOD)
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                botao,
    input  logic [1:0]          mode,
    input  logic                dir,
    output logic [NUM_LEDS-1:0] leds,
    output logic [IDX_W-1:0]    pos,
    output logic                step
);
    localparam logic [IDX_W-1:0] LAST    = IDX_W'(NUM_LEDS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PERIOD - 1);
    mode_t            mode_in;
    mode_t            mode_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [IDX_W-1:0] pos_nxt;
    logic             bounce;
    logic             bounce_nxt;
    logic             pressed;
    logic             press_evt;
    logic             mode_chg;
    logic             counting;
    logic             adv;
    logic             ping;
    logic             down;
    logic             at_end;
    btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_btn (
        .clock     (clock),
        .reset_n   (reset_n),
        .botao     (botao),
        .pressed   (pressed),
        .press_evt (press_evt)
    );
    // a mode switch spends one cycle clearing the counter without advancing
    always_comb begin
        mode_in    = mode_t'(mode);
        mode_chg   = mode_in != mode_q;
        ping       = mode_in == MODE_PINGPONG;
        counting   = mode_in == MODE_HOLD ? pressed : mode_in != MODE_STEP;
        adv        = !mode_chg && (mode_in == MODE_STEP ? press_evt : counting && cnt == CNT_MAX);
        cnt_nxt    = (mode_chg || !counting || cnt == CNT_MAX) ? '0 : cnt + 1'b1;
        down       = (ping ? bounce : dir) == DIR_DOWN;
        at_end     = down ? pos == '0 : pos == LAST;
        pos_nxt    = !adv ? pos :
                     at_end ? (ping ? (down ? IDX_W'(1) : LAST - 1'b1) : (down ? LAST : '0)) :
                     down ? pos - 1'b1 : pos + 1'b1;
        bounce_nxt = (mode_chg && ping) ? dir : (adv && ping && at_end) ? ~bounce : bounce;
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mode_q <= MODE_HOLD;
            cnt    <= '0;
            pos    <= '0;
            leds   <= NUM_LEDS'(1);
            step   <= 1'b0;
            bounce <= DIR_UP;
        end else begin
            mode_q <= mode_in;
            cnt    <= cnt_nxt;
            pos    <= pos_nxt;
            leds   <= NUM_LEDS'(1) << pos_nxt;
            step   <= adv;
            bounce <= bounce_nxt;
        end
    end
endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: directed self-checking bench for led_sequencer (LED_SEQ_DEBOUNCE_EN optional)
module tb_led_sequencer;
    import led_seq_pkg::*;
    localparam int NUM_LEDS  = 4;
    localparam int PERIOD    = 8;
    localparam int DB_CYCLES = 4;
`ifdef LED_SEQ_DEBOUNCE_EN
    localparam int FILT = 2 + DB_CYCLES;
`else
    localparam int FILT = 2;
`endif
    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic       botao   = 1'b1;
    logic       dir     = 1'b0;
    logic [1:0] mode    = MODE_HOLD;
    logic [3:0] leds;
    logic [1:0] pos;
    logic       step;
    int checks = 0;
    int errors = 0;
    always #5 clock = ~clock;
    led_sequencer #(.NUM_LEDS(NUM_LEDS), .PERIOD(PERIOD), .DB_CYCLES(DB_CYCLES)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .botao   (botao),
        .mode    (mode),
        .dir     (dir),
        .leds    (leds),
        .pos     (pos),
        .step    (step)
    );
    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask
    task automatic wait_step(output int n);
        n = 0;
        do begin
            tick(1);
            n++;
        end while (!step && n < 200);
    endtask
    task automatic count_steps(input int n, output int s);
        s = 0;
        repeat (n) begin
            tick(1);
            if (step) s++;
        end
    endtask
    task automatic expect_step(input string tag, input int lat, input int p);
        int n;
        wait_step(n);
        chk({tag, "_lat"}, n, lat);
        chk({tag, "_pos"}, int'(pos), p);
        chk({tag, "_leds"}, int'(leds), 1 << p);
    endtask
    initial begin
        int s;
        int pp_seq[6] = '{3, 2, 1, 0, 1, 2};
        tick(3);
        chk("rst_pos", int'(pos), 0);
        chk("rst_leds", int'(leds), 1);
        chk("rst_step", int'(step), 0);
        reset_n = 1'b1;
        count_steps(50, s);
        chk("idle_steps", s, 0);
        chk("idle_leds", int'(leds), 1);
        // HOLD, counting up with a continuous press
        botao = 1'b0;
        expect_step("hold1", FILT + PERIOD, 1);
        expect_step("hold2", PERIOD, 2);
        expect_step("hold3", PERIOD, 3);
        expect_step("hold4", PERIOD, 0);
        botao = 1'b1;
        count_steps(30, s);
        chk("release_steps", s, 0);
        botao = 1'b0;
        expect_step("repress", FILT + PERIOD, 1);
        botao = 1'b1;
        tick(20);
        // STEP, counting down, one advance per press
        mode = MODE_STEP;
        dir  = 1'b1;
        tick(2);
        botao = 1'b0;
        expect_step("step1", FILT + 1, 0);
        count_steps(100, s);
        chk("hold_no_repeat", s, 0);
        botao = 1'b1;
        tick(20);
        botao = 1'b0;
        expect_step("step2", FILT + 1, 3);
        botao = 1'b1;
        tick(20);
`ifdef LED_SEQ_DEBOUNCE_EN
        repeat (2) begin
            botao = 1'b0;
            tick(2);
            botao = 1'b1;
            tick(2);
        end
        count_steps(20, s);
        chk("glitch_steps", s, 0);
        chk("glitch_pos", int'(pos), 3);
`endif
        botao = 1'b0;
        expect_step("step3", FILT + 1, 2);
        botao = 1'b1;
        tick(20);
        // PINGPONG from pos 2 heading up; dir is ignored once inside
        mode = MODE_PINGPONG;
        dir  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            expect_step($sformatf("pp%0d", i), i == 0 ? PERIOD + 1 : PERIOD, pp_seq[i]);
            if (i == 1) dir = 1'b1;
        end
        // AUTO interrupted by a switch to STEP mid-count
        mode = MODE_AUTO;
        dir  = 1'b0;
        tick(6);
        chk("auto_cnt5", int'(dut.cnt), 5);
        mode = MODE_STEP;
        tick(1);
        chk("sw_cnt", int'(dut.cnt), 0);
        chk("sw_step", int'(step), 0);
        chk("sw_pos", int'(pos), 2);
        mode = MODE_AUTO;
        expect_step("auto", PERIOD + 1, 3);
        tick(3);
        reset_n = 1'b0;
        #1;
        chk("async_leds", int'(leds), 1);
        chk("async_pos", int'(pos), 0);
        chk("async_step", int'(step), 0);
        tick(2);
        reset_n = 1'b1;
        expect_step("post_rst", PERIOD + 1, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
